// File: rtl/shifter_seq32.sv
// Sequential shift unit: shifts one bit per clock, valid/ready request and response.
// Ports: clk, rst (async active-low), i_valid/i_ready, a, s, op, o_valid/o_ready, y, busy.
module shifter_seq32 #(
   parameter int N  = 32,
   parameter int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   output logic          i_ready,
   input  logic [N-1:0]  a,
   input  logic [SW-1:0] s,
   input  logic [1:0]    op,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [N-1:0]  y,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [N-1:0]  r_data;
   logic [N-1:0]  w_data_nxt;
   logic [SW-1:0] r_cnt;
   logic [SW-1:0] w_cnt_nxt;
   logic [1:0]    r_op;
   logic [1:0]    w_op_nxt;
   logic [N-1:0]  w_step;

   // One-position step of the held operand
   always_comb begin
      w_step = r_data;
      unique case (r_op)
         2'b00: w_step = {r_data[N-2:0], 1'b0};
         2'b01: w_step = {1'b0, r_data[N-1:1]};
         2'b10: w_step = {r_data[N-1], r_data[N-1:1]};
         2'b11: w_step = {r_data[0], r_data[N-1:1]};
         default: w_step = r_data;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_cnt_nxt   = r_cnt;
      w_op_nxt    = r_op;
      unique case (r_state)
         IDLE: begin
            if (i_valid) begin
               w_data_nxt  = a;
               w_cnt_nxt   = s;
               w_op_nxt    = op;
               w_state_nxt = (s == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            w_data_nxt = w_step;
            w_cnt_nxt  = r_cnt - SW'(1);
            if (r_cnt == SW'(1))
               w_state_nxt = DONE;
         end
         DONE: begin
            if (o_ready)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_data  <= '0;
         r_cnt   <= '0;
         r_op    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_data  <= w_data_nxt;
         r_cnt   <= w_cnt_nxt;
         r_op    <= w_op_nxt;
      end
   end

   assign i_ready = (r_state == IDLE);
   assign o_valid = (r_state == DONE);
   assign busy    = (r_state != IDLE);
   assign y       = r_data;

endmodule

// File: doc/shifter_seq32.md
Name: shifter_seq32

Overview:
- Multi-cycle, area-reduced shift unit for the ALU. It performs the same functions as the combinational barrel shifters (logical left, logical right, arithmetic right), plus rotate-right.
- It shifts one bit position per clock instead of using a log-depth mux tree.
- Operands are accepted through a valid/ready request channel; the result is returned through a valid/ready response channel.
- It sits between the ALU operand latch and the writeback mux, on builds where shifter area matters more than latency.

Parameters:
- N, 32, data width in bits; power of two, N >= 2.
- SW, $clog2(N), shift-amount width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- i_valid  input  1  request valid.
- i_ready  output  1  unit can accept a request.
- a  input  N  operand.
- s  input  SW  shift amount, unsigned, 0..N-1.
- op  input  2  operation: 00 = logical left (<<), 01 = logical right (>>), 10 = arithmetic right (>>>), 11 = rotate right.
- o_valid  output  1  result valid.
- o_ready  input  1  consumer accepts the result.
- y  output  N  result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- States: IDLE, SHIFT, DONE. Internal registers: data[N-1:0], cnt[SW-1:0], op_q[1:0].
- Reset (rst=0, asynchronous, any state):
  - state = IDLE; data, cnt, op_q = 0.
  - Outputs: i_ready=1, o_valid=0, busy=0, y=0.
  - Reset mid-operation aborts it; no result is produced.
- IDLE:
  - i_ready=1.
  - On a rising edge with i_valid=1: data<=a, cnt<=s, op_q<=op.
  - Next state: DONE if s==0, else SHIFT.
  - a, s and op are sampled only at acceptance; later input changes are ignored.
- SHIFT:
  - i_ready=0, o_valid=0.
  - Each edge shifts data by exactly one position according to op_q:
    - 00: {data[N-2:0],1'b0}
    - 01: {1'b0,data[N-1:1]}
    - 10: {data[N-1],data[N-1:1]}
    - 11: {data[0],data[N-1:1]}
  - Each edge also does cnt<=cnt-1. When cnt==1 at the edge, next state = DONE.
  - o_ready is ignored in this state.
- DONE:
  - o_valid=1, y=data, stable until the handshake completes.
  - On an edge with o_ready=1: state<=IDLE, so i_ready=1 on the following cycle.
  - If o_ready=0, hold indefinitely.
- Handshake timing:
  - No bypass: a request cannot be accepted in the same cycle a result is consumed.
  - Issue rate is at most one operation per max(s,1)+1 cycles.
- Latency: o_valid rises max(s,1) clock edges after the acceptance edge. For s=0 this is 1 edge; for s=31 it is 31 edges.
- y equivalence: y in DONE must equal a<<s, a>>s, $signed(a)>>>s, or (a>>s)|(a<<(N-s)) (rotate right, with s=0 giving a), matching the combinational shifters bit-for-bit.
- No X propagation from any output after reset, in any state.
- busy = (state != IDLE).

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release → i_ready=1, o_valid=0, busy=0, y=0.
- Logical left: a=32'h0000_00F1, s=4, op=00, o_ready=1 → o_valid after 4 edges, y=32'h0000_0F10; i_ready=1 the cycle after the handshake.
- Arithmetic vs logical right: a=32'h8000_0010, s=31, op=10 → y=32'hFFFF_FFFF after 31 edges; same with op=01 → y=32'h0000_0001.
- Rotate and zero shift:
  - a=32'h1234_5678, s=8, op=11 → y=32'h7812_3456.
  - s=0, op=00 → y=a, o_valid exactly 1 edge after acceptance.
- Backpressure: hold o_ready=0 for 5 cycles in DONE with input a changing → y and o_valid stable, i_ready=0; on o_ready=1, return to IDLE.
- Mid-operation reset plus random sweep:
  - Assert rst=0 during SHIFT (s=20) → outputs return to reset values immediately; no o_valid after release.
  - Then 1024 random (a,s,op) requests with random o_ready stalls → every result matches the behavioural <<, >>, >>>, rotate reference; error count = 0.
